// File: rtl/wrr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wrr_pkg                                                |
// | Description : Shared constants, decision encoding and index-width    |
// |               helper for the weighted round-robin arbiter.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package wrr_pkg;

   localparam int WRR_N_DEF  = 6;
   localparam int WRR_WW_DEF = 4;

   // Per-cycle arbitration outcome.
   typedef enum logic [1:0] {
      DEC_IDLE = 2'd0,
      DEC_HOLD = 2'd1,
      DEC_PICK = 2'd2
   } wrr_dec_e;

   // Ceiling log2, with a minimum result of 1 so a 2-requester index is 1 bit.
   function automatic int clog2_f(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_pick                                                |
// | Description : Combinational cyclic first-one search. Scans req at    |
// |               positions base+1, base+2, ... base+N (mod N), so base  |
// |               itself is the last candidate.                          |
// | Ports       : req   [N]  - request vector                            |
// |               base  [IW] - position the search starts after          |
// |               found      - at least one request is set               |
// |               idx   [IW] - index of the first request found          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_pick
   import wrr_pkg::*;
#(
   parameter int N  = WRR_N_DEF,
   parameter int IW = clog2_f(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   output logic          found,
   output logic [IW-1:0] idx
);

   localparam logic [IW:0] C_N = (IW+1)'(N);

   // Doubling the vector lets base+k index it directly for k in 1..N,
   // avoiding any modulo on the scan itself.
   logic [2*N-1:0] w_dbl;
   logic [IW:0]    w_pos;

   assign w_dbl = {req, req};

   // Scan from the far end so the nearest hit is the one that sticks.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      w_pos = '0;
      for (int k = N; k >= 1; k--) begin
         w_pos = {1'b0, base} + (IW+1)'(k);
         if (w_dbl[w_pos]) begin
            found = 1'b1;
            idx   = (w_pos >= C_N) ? IW'(w_pos - C_N) : IW'(w_pos);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wrr_arbiter                                            |
// | Description : Weighted round-robin arbiter with registered one-hot   |
// |               grant, per-requester burst tenure and a lock input.    |
// | Ports       : clk, rst_n (async, active-low)                         |
// |               req    [N]     - level-sensitive requests              |
// |               weight [N*WW]  - packed tenure weights (0 acts as 1)   |
// |               lock           - keep current owner regardless credit  |
// |               grant  [N]     - one-hot grant, zero when idle         |
// |               grant_valid    - grant is non-zero                     |
// |               grant_idx [IW] - owner index, held while idle          |
// |               credit [WW]    - remaining tenure incl. current cycle  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wrr_arbiter
   import wrr_pkg::*;
#(
   parameter int N  = WRR_N_DEF,
   parameter int WW = WRR_WW_DEF,
   parameter int IW = clog2_f(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] weight,
   input  logic            lock,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [IW-1:0]   grant_idx,
   output logic [WW-1:0]   credit
);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_base;
   logic [IW-1:0] w_pick_idx;
   logic          w_found;
   logic          w_owner_req;
   logic [WW-1:0] w_pick_w;
   logic [WW-1:0] w_pick_weff;
   logic [WW-1:0] w_hold_credit;
   logic [N-1:0]  w_pick_onehot;
   wrr_dec_e      w_dec;

   // While a grant is active the search continues after the owner; when
   // idle it continues after the last winner (ptr, N-1 out of reset).
   assign w_base = grant_valid ? grant_idx : r_ptr;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .base  (w_base),
      .found (w_found),
      .idx   (w_pick_idx)
   );

   // Index-driven muxes written as compare loops to keep widths exact.
   always_comb begin
      w_owner_req   = 1'b0;
      w_pick_w      = '0;
      w_pick_onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == IW'(i)) w_owner_req = req[i];
         if (w_pick_idx == IW'(i)) begin
            w_pick_w         = weight[i*WW +: WW];
            w_pick_onehot[i] = 1'b1;
         end
      end
   end

   assign w_pick_weff = (w_pick_w == '0) ? WW'(1) : w_pick_w;

   // Under lock the credit counts down but never below 1, so the owner
   // still has a valid tenure the moment lock drops.
   assign w_hold_credit = (lock && (credit <= WW'(1))) ? WW'(1) : (credit - WW'(1));

   always_comb begin
      w_dec = DEC_IDLE;
      if (grant_valid && w_owner_req && (lock || (credit > WW'(1))))
         w_dec = DEC_HOLD;
      else if (w_found)
         w_dec = DEC_PICK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         credit      <= '0;
         r_ptr       <= IW'(N-1);
      end else begin
         case (w_dec)
            DEC_HOLD: begin
               credit <= w_hold_credit;
            end
            DEC_PICK: begin
               grant       <= w_pick_onehot;
               grant_valid <= 1'b1;
               grant_idx   <= w_pick_idx;
               credit      <= w_pick_weff;
               r_ptr       <= w_pick_idx;
            end
            default: begin
               grant       <= '0;
               grant_valid <= 1'b0;
               credit      <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter with registered one-hot grant.
- Each requester holds its grant for up to a programmable number of consecutive cycles (weight), and can be held longer with a lock input.
- Successor to the single-cycle round-robin arbiter; used in front of shared buses and memory ports where requesters need burst tenure and atomic sequences.

Parameters:
- N, 6, number of requesters (N >= 2).
- WW, 4, width of each per-requester weight field.
- IW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  request vector, level-sensitive.
- weight  input  N*WW  packed weights; requester i uses bits [i*WW +: WW].
- lock  input  1  while high, the current owner keeps its grant regardless of credit.
- grant  output  N  registered one-hot grant; all zeros when idle.
- grant_valid  output  1  registered; high iff grant is non-zero.
- grant_idx  output  IW  registered index of the owner; holds its last value when idle.
- credit  output  WW  registered remaining tenure of the current owner, including the current cycle; 0 when idle.

Behaviour:
- Reset values: grant=0, grant_valid=0, grant_idx=0, credit=0, internal pointer ptr=N-1. Because ptr=N-1, the first search after reset starts at requester 0.
- Latency: req is sampled at a clock edge, and the resulting grant is visible after that same edge (one cycle from request to grant).
- Effective weight: w_eff(i) = (weight[i]==0) ? 1 : weight[i]. The weight is sampled only when a grant is issued; later changes do not affect the current tenure.
- Per-cycle decision, evaluated in priority order:
  1. HOLD: grant_valid && req[owner] && (lock || credit>1). The owner is kept. credit decrements by 1 when lock=0. When lock=1, credit decrements but saturates at 1.
  2. PICK: otherwise, search cyclically from owner+1 (or ptr+1 when idle) through N positions, ending at the owner itself. The first i with req[i]=1 wins: grant=onehot(i), grant_idx=i, credit=w_eff(i), ptr=i.
  3. IDLE: no request found. grant=0, grant_valid=0, credit=0; ptr and grant_idx unchanged.
- Sole requester: if it exhausts its credit, the search wraps back to itself and it is re-granted with a fresh w_eff. Its grant stays high continuously.
- Early release: if the owner drops req before its credit is exhausted, the next requester is picked that same edge. No dead cycle is inserted when other requests are pending.
- Lock with no request: if lock=1 but req[owner]=0, lock is ignored and PICK applies.
- A lock asserted while idle has no effect.
- Mutual exclusion: grant is always one-hot or zero. grant_valid == |grant.
- Fairness: with all requesters continuously active and lock=0, requester i receives exactly w_eff(i) cycles per round, in ascending cyclic order.
- Reset mid-tenure: all outputs and ptr return to their reset values asynchronously. The first grant after release goes to the lowest-index active requester.
- Arithmetic: credit is WW bits, with no overflow because the maximum load is 2^WW-1. The cyclic index (base+k) mod N is computed without a divider; a doubled request vector or a rotate is used.

Decomposition:
- Shared package wrr_pkg holds the index-width helper function clog2_f and the default constants WRR_N_DEF=6 and WRR_WW_DEF=4.
- Sub-module rr_pick (combinational): inputs req[N], base[IW]; outputs found and idx[IW]. It implements the cyclic first-one search starting at base+1.
- wrr_arbiter instantiates rr_pick and owns the state registers and the HOLD/PICK/IDLE decision.

Test Plan (bench uses N=4, WW=3 unless noted):
- Reset, then req=4'b1111 with weights {1,2,3,1} (req0..req3), lock=0 -> grant_idx sequence 0,1,1,2,2,2,3,0,1,1,... repeating with an 7-cycle period; credit for req1 reads 2,1.
- Only req2 is high with weight 3 for 10 cycles -> grant=4'b0100 continuously; credit sequence 3,2,1,3,2,1,...
- req=4'b0011 with w0=4; req0 drops in its 2nd tenure cycle -> grant moves to req1 on the next edge, with no idle cycle.
- Owner req0 with w0=1, lock=1 for 5 cycles while req1 is high -> req0 is held for 5 cycles with credit=1; grant goes to req1 the edge after lock falls.
- weight field 0 for every requester and req=4'b1010 -> grants alternate 1,3,1,3 with one cycle each.
- Assert rst_n low mid-tenure of req3, release with req=4'b1001 -> outputs are 0 during reset; the first grant goes to req0. Also run N=6, WW=4 with random req: assert one-hot grant and per-round fairness counts.
